vga_timing: RTL
===============

// Module: vga_timing
// PURPOSE
//  Free-running VGA raster timing generator for 1024x768@60 on the 65 MHz pixel clock.
//  Consumes the vga_pkg timing constants and produces registered hcount/vcount, blanking and sync.
//  Sits directly downstream of vga_pkg and upstream of every draw/overlay stage (background, cards, text).
// PARAMETERS
//  H_ACTIVE   vga_pkg::HBLANK_START  first blank pixel column (1024)
//  H_SS       vga_pkg::HSYNC_START   first hsync column (1048)
//  H_SE       vga_pkg::HSYNC_STOP    first column after hsync (1184)
//  H_TOTAL    vga_pkg::HBLANK_STOP   columns per line (1344); hcount max = H_TOTAL-1
//  V_ACTIVE   vga_pkg::VBLANK_START  first blank line (768)
//  V_SS       vga_pkg::VSYNC_START   first vsync line (771)
//  V_SE       vga_pkg::VSYNC_STOP    first line after vsync (777)
//  V_TOTAL    vga_pkg::VBLANK_STOP   lines per frame (806)
//  CNT_W      11                     counter width; must satisfy 2**CNT_W >= max(H_TOTAL,V_TOTAL)
// PORTS
//  clk        in   1      65 MHz pixel clock, single clock domain
//  rst_n      in   1      asynchronous, active-low reset
//  pix_en     in   1      clock enable; low = hold all state (tie 1 in normal use)
//  hcount     out  CNT_W  current column, 0..H_TOTAL-1
//  vcount     out  CNT_W  current line, 0..V_TOTAL-1
//  hblnk      out  1      1 when hcount >= H_ACTIVE
//  hsync      out  1      1 when H_SS <= hcount < H_SE (active-high, polarity fixed at top level)
//  vblnk      out  1      1 when vcount >= V_ACTIVE
//  vsync      out  1      1 when V_SS <= vcount < V_SE (active-high)
//  sof        out  1      start-of-frame pulse (feature-gated, see CONFIGURATION)
//  frame_cnt  out  16     frame counter (feature-gated)
// BEHAVIOUR
//  - Reset (rst_n=0, async): hcount=vcount=0, all flags 0, sof=0, frame_cnt=0.
//  - Every outputs is a flop; flags are decoded from the NEXT counter values so flags and counters
//    describe the same pixel in the same cycle (zero relative skew, no combinational outputs).
//  - Per enabled cycle: hcount+1; at hcount==H_TOTAL-1 -> hcount=0 and vcount+1;
//    at hcount==H_TOTAL-1 && vcount==V_TOTAL-1 -> both 0 (frame wrap). Never exceeds max.
//  - Flags after reset: counters (0,0) => hblnk=hsync=vblnk=vsync=0, consistent with decode.
//  - First enabled edge after reset release: hcount=1. pix_en=0 freezes counters, flags, frame_cnt;
//    sof is forced 0 while pix_en=0 and re-asserts only on a fresh transition into (0,0).
//  - Reset mid-frame: immediate return to (0,0) regardless of pix_en; no partial-line recovery.
//  - Parameter check at elaboration: H_ACTIVE<H_SS<H_SE<=H_TOTAL, same for V, CNT_W fit;
//    violation -> $error.
// CONFIGURATION
//  VGA_TIMING_FRAME_CNT_EN defined: sof=1 for exactly one enabled cycle when counters enter (0,0)
//    via frame wrap (not at reset); frame_cnt increments on that same edge, wraps 0xFFFF->0.
//  Not defined: sof and frame_cnt tied to 0; ports remain so instantiations are identical.
// STRUCTURE
//  vga_pkg: add H_TOTAL/V_TOTAL aliases, CNT_W localparam, typedef logic [CNT_W-1:0] vga_cnt_t.
//  Sub-module vga_wrap_cnt (en, max, count, wrap) instanced twice: horizontal (en=pix_en)
//  and vertical (en=pix_en & h.wrap). Flag decode and sof/frame_cnt live in vga_timing.
// TESTING
//  1 rst_n=0 mid-run -> all outputs 0 within same cycle (async); release -> hcount 1 on next edge.
//  2 line scan -> hblnk rises at hcount=1024, hsync 1 for hcount 1048..1183 (136 cycles), hblnk falls at 0.
//  3 hcount=1343,vcount=10 -> next edge hcount=0,vcount=11; vcount unchanged on all other edges.
//  4 full frame -> vblnk for lines 768..805, vsync lines 771..776 (6*1344 cycles), 1344*806 cycles/frame.
//  5 pix_en=0 for 50 cycles at hcount=1047 -> all outputs frozen; resume -> hsync rises next edge.
//  6 FRAME_CNT_EN: 3 frames -> sof 3 single-cycle pulses at (0,0), frame_cnt 0->3; off -> both stay 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Timing constants for the 1024x768@60 raster (65 MHz pixel clock) and the shared counter type.
package vga_pkg;

   localparam int HBLANK_START = 1024;
   localparam int HSYNC_START  = 1048;
   localparam int HSYNC_STOP   = 1184;
   localparam int HBLANK_STOP  = 1344;

   localparam int VBLANK_START = 768;
   localparam int VSYNC_START  = 771;
   localparam int VSYNC_STOP   = 777;
   localparam int VBLANK_STOP  = 806;

   // Totals are the blank-stop points: a line/frame ends where blanking ends.
   localparam int H_TOTAL = HBLANK_STOP;
   localparam int V_TOTAL = VBLANK_STOP;

   localparam int CNT_W = 11;

   typedef logic [CNT_W-1:0] vga_cnt_t;

endpackage

// File: rtl/vga_wrap_cnt.sv
// Enabled up-counter that returns to zero after reaching max; exposes its next value and wrap strobe.
module vga_wrap_cnt
   import vga_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] max,
   output logic [W-1:0] count,
   output logic [W-1:0] count_nxt,
   output logic         wrap
);

   // >= keeps the counter bounded even if max is lowered at run time.
   assign wrap = en && (count >= max);

   always_comb begin
      count_nxt = count;
      if (wrap) begin
         count_nxt = '0;
      end else if (en) begin
         count_nxt = count + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/vga_timing.sv
// Free-running VGA raster timing: registered counters with flags decoded from the next counter values.
// Optional start-of-frame pulse and frame counter are enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing #(
   parameter int H_ACTIVE = vga_pkg::HBLANK_START,
   parameter int H_SS     = vga_pkg::HSYNC_START,
   parameter int H_SE     = vga_pkg::HSYNC_STOP,
   parameter int H_TOTAL  = vga_pkg::HBLANK_STOP,
   parameter int V_ACTIVE = vga_pkg::VBLANK_START,
   parameter int V_SS     = vga_pkg::VSYNC_START,
   parameter int V_SE     = vga_pkg::VSYNC_STOP,
   parameter int V_TOTAL  = vga_pkg::VBLANK_STOP,
   parameter int CNT_W    = vga_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pix_en,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hblnk,
   output logic             hsync,
   output logic             vblnk,
   output logic             vsync,
   output logic             sof,
   output logic [15:0]      frame_cnt
);

   if (!(H_ACTIVE < H_SS && H_SS < H_SE && H_SE <= H_TOTAL)) begin : g_bad_h
      $error("vga_timing: horizontal timing parameters out of order");
   end
   if (!(V_ACTIVE < V_SS && V_SS < V_SE && V_SE <= V_TOTAL)) begin : g_bad_v
      $error("vga_timing: vertical timing parameters out of order");
   end
   if ((1 << CNT_W) < H_TOTAL || (1 << CNT_W) < V_TOTAL) begin : g_bad_w
      $error("vga_timing: CNT_W too narrow for H_TOTAL/V_TOTAL");
   end

   localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_MAX   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] H_SS_C  = CNT_W'(H_SS);
   localparam logic [CNT_W-1:0] H_SE_C  = CNT_W'(H_SE);
   localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] V_SS_C  = CNT_W'(V_SS);
   localparam logic [CNT_W-1:0] V_SE_C  = CNT_W'(V_SE);

   logic [CNT_W-1:0] h_nxt;
   logic [CNT_W-1:0] v_nxt;
   logic             h_wrap;
   logic             v_wrap;

   vga_wrap_cnt #(.W(CNT_W)) u_hcnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (pix_en),
      .max       (H_MAX),
      .count     (hcount),
      .count_nxt (h_nxt),
      .wrap      (h_wrap)
   );

   // v_wrap therefore marks the frame wrap: last pixel of last line on an enabled cycle.
   vga_wrap_cnt #(.W(CNT_W)) u_vcnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (pix_en & h_wrap),
      .max       (V_MAX),
      .count     (vcount),
      .count_nxt (v_nxt),
      .wrap      (v_wrap)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hblnk <= 1'b0;
         hsync <= 1'b0;
         vblnk <= 1'b0;
         vsync <= 1'b0;
      end else if (pix_en) begin
         hblnk <= (h_nxt >= H_ACT_C);
         hsync <= (h_nxt >= H_SS_C) && (h_nxt < H_SE_C);
         vblnk <= (v_nxt >= V_ACT_C);
         vsync <= (v_nxt >= V_SS_C) && (v_nxt < V_SE_C);
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sof       <= 1'b0;
         frame_cnt <= '0;
      end else begin
         sof <= v_wrap;
         if (v_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end
`else
   logic unused_frame_wrap;
   assign unused_frame_wrap = v_wrap;
   assign sof               = 1'b0;
   assign frame_cnt         = '0;
`endif

endmodule
